// File: rtl/speed_profile_planner_if.sv
// Request/result bundle between the move decoder and the speed profile planner.
// The decoder side (master) drives the move request and reads back the timings;
// the planner side (slave) does the opposite.
interface speed_profile_planner_if #(
    parameter int N_AXES = 5,
    parameter int WIDTH  = 32
);
    logic                      start;
    logic [N_AXES*WIDTH-1:0]   num;
    logic [N_AXES*WIDTH-1:0]   speed;
    logic [N_AXES*WIDTH-1:0]   acceleration;
    logic [N_AXES*WIDTH-1:0]   jerk;
    logic [N_AXES*WIDTH-1:0]   n_total;
    logic [N_AXES*WIDTH-1:0]   nn;
    logic [N_AXES*WIDTH-1:0]   t0;
    logic [N_AXES*WIDTH-1:0]   tna;
    logic [N_AXES*WIDTH-1:0]   delta;
    logic [N_AXES-1:0]         dir;
    logic [N_AXES-1:0]         err;
    logic                      busy;
    logic                      finish;

    modport master (
        output start, num, speed, acceleration, jerk,
        input  n_total, nn, t0, tna, delta, dir, err, busy, finish
    );

    modport slave (
        input  start, num, speed, acceleration, jerk,
        output n_total, nn, t0, tna, delta, dir, err, busy, finish
    );
endinterface

// File: rtl/speed_profile_planner.sv
// Multi-axis trapezoidal step-timing planner. For every axis it turns step
// count, cruise speed, acceleration and start speed into step periods (in clock
// cycles) using one shared restoring divider, walking the axes one at a time.
module speed_profile_planner #(
    parameter int          N_AXES = 5,
    parameter int          WIDTH  = 32,
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic                     clk,
    input  logic                     reset,
    speed_profile_planner_if.slave   bus
);
    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(DW + 1);
    localparam int AW = (N_AXES > 1) ? $clog2(N_AXES) : 1;
    localparam logic [DW-1:0] CLK_DIVIDEND = DW'(CLK_HZ);

    typedef enum logic [3:0] {
        IDLE, LATCH, AXIS_SETUP, DIV_TNA, DIV_T0, MUL,
        DIV_NN, CLAMP, DIV_DELTA, STORE, DONE
    } state_t;

    state_t                  state;
    logic [AW-1:0]           axis;

    // Inputs captured at the accepted start; the bus may change during a run.
    logic [N_AXES*WIDTH-1:0] lat_num, lat_spd, lat_acc, lat_jrk;

    // Working set for the axis being planned.
    logic [WIDTH-1:0]        cur_n, cur_spd, cur_acc, cur_jrk;
    logic                    cur_dir, cur_err;
    logic [WIDTH-1:0]        r_tna, r_t0, r_nn, r_delta;
    logic [DW-1:0]           r_diff;

    // Shared restoring divider: remainder, shifting dividend/quotient, divisor.
    logic [WIDTH-1:0]        div_rem;
    logic [DW-1:0]           div_quo;
    logic [WIDTH-1:0]        div_dvs;
    logic [CW-1:0]           div_cnt;
    logic                    div_active;

    // Registered results.
    logic [N_AXES*WIDTH-1:0] n_total_r, nn_r, t0_r, tna_r, delta_r;
    logic [N_AXES-1:0]       dir_r, err_r;
    logic                    busy_r, finish_r;

    assign bus.n_total = n_total_r;
    assign bus.nn      = nn_r;
    assign bus.t0      = t0_r;
    assign bus.tna     = tna_r;
    assign bus.delta   = delta_r;
    assign bus.dir     = dir_r;
    assign bus.err     = err_r;
    assign bus.busy    = busy_r;
    assign bus.finish  = finish_r;

    // Quotients that do not fit the output field clamp to all-ones.
    function automatic logic [WIDTH-1:0] sat(input logic [DW-1:0] q);
        return (|q[DW-1:WIDTH]) ? '1 : q[WIDTH-1:0];
    endfunction

    logic [WIDTH-1:0] sel_num, sel_spd, sel_acc, sel_jrk, sel_abs;
    assign sel_num = lat_num[axis*WIDTH +: WIDTH];
    assign sel_spd = lat_spd[axis*WIDTH +: WIDTH];
    assign sel_acc = lat_acc[axis*WIDTH +: WIDTH];
    assign sel_jrk = lat_jrk[axis*WIDTH +: WIDTH];
    assign sel_abs = sel_num[WIDTH-1] ? -sel_num : sel_num;

    logic [DW-1:0]    div_a;
    logic [WIDTH-1:0] div_b;
    logic             div_state;
    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_next;
    logic [DW-1:0]    quo_next;
    logic             div_last;
    logic             nn_over;
    logic [WIDTH-1:0] nn_clamped;

    // Operand selection for the divider, one restoring step, and the short-move clamp.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        div_a     = '0;
        div_b     = '0;
        div_state = 1'b1;
        case (state)
            DIV_TNA:   begin div_a = CLK_DIVIDEND; div_b = cur_spd; end
            DIV_T0:    begin div_a = CLK_DIVIDEND; div_b = cur_jrk; end
            DIV_NN:    begin div_a = r_diff;       div_b = cur_acc; end
            DIV_DELTA: begin div_a = {{WIDTH{1'b0}}, r_t0 - r_tna}; div_b = r_nn; end
            default:   div_state = 1'b0;
        endcase

        rem_shift  = {div_rem, div_quo[DW-1]};
        rem_ge     = rem_shift >= {1'b0, div_dvs};
        rem_next   = rem_ge ? WIDTH'(rem_shift - {1'b0, div_dvs}) : rem_shift[WIDTH-1:0];
        quo_next   = {div_quo[DW-2:0], rem_ge};
        div_last   = div_active && (div_cnt == CW'(DW - 1));

        nn_over    = {r_nn, 1'b0} > {1'b0, cur_n};
        nn_clamped = nn_over ? (cur_n >> 1) : r_nn;
    end

    // Planner FSM with the divider datapath and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            axis       <= '0;
            lat_num    <= '0;
            lat_spd    <= '0;
            lat_acc    <= '0;
            lat_jrk    <= '0;
            cur_n      <= '0;
            cur_spd    <= '0;
            cur_acc    <= '0;
            cur_jrk    <= '0;
            cur_dir    <= 1'b0;
            cur_err    <= 1'b0;
            r_tna      <= '0;
            r_t0       <= '0;
            r_nn       <= '0;
            r_delta    <= '0;
            r_diff     <= '0;
            div_rem    <= '0;
            div_quo    <= '0;
            div_dvs    <= '0;
            div_cnt    <= '0;
            div_active <= 1'b0;
            n_total_r  <= '0;
            nn_r       <= '0;
            t0_r       <= '0;
            tna_r      <= '0;
            delta_r    <= '0;
            dir_r      <= '0;
            err_r      <= '0;
            busy_r     <= 1'b0;
            finish_r   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            // Divider: one load cycle, then 2*WIDTH shift/subtract steps.
            if (div_state) begin
                if (!div_active) begin
                    div_rem    <= '0;
                    div_quo    <= div_a;
                    div_dvs    <= div_b;
                    div_cnt    <= '0;
                    div_active <= 1'b1;
                end else begin
                    div_rem <= rem_next;
                    div_quo <= quo_next;
                    div_cnt <= div_cnt + CW'(1);
                    if (div_last) div_active <= 1'b0;
                end
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        lat_num  <= bus.num;
                        lat_spd  <= bus.speed;
                        lat_acc  <= bus.acceleration;
                        lat_jrk  <= bus.jerk;
                        busy_r   <= 1'b1;
                        finish_r <= 1'b0;
                        state    <= LATCH;
                    end
                end
                LATCH: begin
                    axis  <= '0;
                    state <= AXIS_SETUP;
                end
                AXIS_SETUP: begin
                    cur_n   <= sel_abs;
                    cur_dir <= sel_num[WIDTH-1];
                    cur_spd <= sel_spd;
                    cur_acc <= sel_acc;
                    cur_jrk <= sel_jrk;
                    cur_err <= 1'b0;
                    r_tna   <= '0;
                    r_t0    <= '0;
                    r_nn    <= '0;
                    r_delta <= '0;
                    if (sel_abs == '0) begin
                        state <= STORE;
                    end else if (sel_spd == '0 || sel_jrk == '0) begin
                        cur_err <= 1'b1;
                        state   <= STORE;
                    end else begin
                        state <= DIV_TNA;
                    end
                end
                DIV_TNA: begin
                    if (div_last) begin
                        r_tna <= sat(quo_next);
                        state <= DIV_T0;
                    end
                end
                DIV_T0: begin
                    if (div_last) begin
                        r_t0  <= sat(quo_next);
                        state <= MUL;
                    end
                end
                MUL: begin
                    // Halving the difference here equals dividing by 2*acceleration later.
                    if (cur_spd > cur_jrk && cur_acc != '0) begin
                        r_diff <= (DW'(cur_spd) * DW'(cur_spd) - DW'(cur_jrk) * DW'(cur_jrk)) >> 1;
                        state  <= DIV_NN;
                    end else begin
                        r_nn  <= '0;
                        r_t0  <= r_tna;
                        state <= CLAMP;
                    end
                end
                DIV_NN: begin
                    if (div_last) begin
                        r_nn  <= sat(quo_next);
                        state <= CLAMP;
                    end
                end
                CLAMP: begin
                    r_nn <= nn_clamped;
                    if (nn_clamped != '0) begin
                        state <= DIV_DELTA;
                    end else begin
                        r_delta <= '0;
                        state   <= STORE;
                    end
                end
                DIV_DELTA: begin
                    if (div_last) begin
                        r_delta <= sat(quo_next);
                        state   <= STORE;
                    end
                end
                STORE: begin
                    n_total_r[axis*WIDTH +: WIDTH] <= cur_n;
                    nn_r[axis*WIDTH +: WIDTH]      <= r_nn;
                    t0_r[axis*WIDTH +: WIDTH]      <= r_t0;
                    tna_r[axis*WIDTH +: WIDTH]     <= r_tna;
                    delta_r[axis*WIDTH +: WIDTH]   <= r_delta;
                    dir_r[axis]                    <= cur_dir;
                    err_r[axis]                    <= cur_err;
                    if (axis == AW'(N_AXES - 1)) begin
                        state <= DONE;
                    end else begin
                        axis  <= axis + AW'(1);
                        state <= AXIS_SETUP;
                    end
                end
                DONE: begin
                    busy_r   <= 1'b0;
                    finish_r <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_speed_profile_planner.sv
// Scoreboard bench for speed_profile_planner: each accepted request pushes its
// hand-computed result set; a monitor pops and compares on every finish rise.
module tb_speed_profile_planner;
    localparam int N     = 5;
    localparam int W     = 32;
    localparam int BOUND = N * (8 * W + 10) + 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    speed_profile_planner_if #(.N_AXES(N), .WIDTH(W)) bus ();

    speed_profile_planner #(.N_AXES(N), .WIDTH(W), .CLK_HZ(50_000_000)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [N*W-1:0] n_total, nn, t0, tna, delta;
        logic [N-1:0]   dir, err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Stimulus set A (set B replaces axis 2 with a copy of axis 0).
    int num_a [N] = '{2200, -60, 0, 500, 300};
    int spd_a [N] = '{100, 100, 100, 100, 5};
    int acc_a [N] = '{100, 100, 100, 100, 100};
    int jrk_a [N] = '{10, 10, 10, 0, 10};

    // Hand-computed results for set A.
    int e_n   [N] = '{2200, 60, 0, 500, 300};
    int e_nn  [N] = '{49, 30, 0, 0, 0};
    int e_t0  [N] = '{5000000, 5000000, 0, 0, 10000000};
    int e_tna [N] = '{500000, 500000, 0, 0, 10000000};
    int e_dl  [N] = '{91836, 150000, 0, 0, 0};
    int e_dir [N] = '{0, 1, 0, 0, 0};
    int e_err [N] = '{0, 0, 0, 1, 0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_set(input bit set_b);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (set_b && i == 2) ? 0 : i;
            bus.num[i*W +: W]          = num_a[k];
            bus.speed[i*W +: W]        = spd_a[k];
            bus.acceleration[i*W +: W] = acc_a[k];
            bus.jerk[i*W +: W]         = jrk_a[k];
        end
    endtask

    function automatic exp_t build_exp(input bit set_b);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (set_b && i == 2) ? 0 : i;
            e.n_total[i*W +: W] = e_n[k];
            e.nn[i*W +: W]      = e_nn[k];
            e.t0[i*W +: W]      = e_t0[k];
            e.tna[i*W +: W]     = e_tna[k];
            e.delta[i*W +: W]   = e_dl[k];
            e.dir[i]            = e_dir[k][0];
            e.err[i]            = e_err[k][0];
        end
        return e;
    endfunction

    // Wait (bounded) until every pushed expectation has been consumed.
    task automatic run_wait(output int cycles);
        cycles = 0;
        while (sb.size() != 0 && cycles < 3000) begin
            @(negedge clk);
            cycles++;
        end
        check("run_completes_pending", sb.size(), 0);
    endtask

    // Monitor: compare the oldest expectation on each rising finish.
    logic fin_d = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            fin_d = 1'b0;
        end else begin
            if (bus.finish && !fin_d) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_finish: got finish=1 expected no pending result");
                end else begin
                    e = sb.pop_front();
                    for (int i = 0; i < N; i++) begin
                        check($sformatf("ax%0d_n_total", i), bus.n_total[i*W +: W], e.n_total[i*W +: W]);
                        check($sformatf("ax%0d_nn", i),      bus.nn[i*W +: W],      e.nn[i*W +: W]);
                        check($sformatf("ax%0d_t0", i),      bus.t0[i*W +: W],      e.t0[i*W +: W]);
                        check($sformatf("ax%0d_tna", i),     bus.tna[i*W +: W],     e.tna[i*W +: W]);
                        check($sformatf("ax%0d_delta", i),   bus.delta[i*W +: W],   e.delta[i*W +: W]);
                        check($sformatf("ax%0d_dir", i),     64'(bus.dir[i]),       64'(e.dir[i]));
                        check($sformatf("ax%0d_err", i),     64'(bus.err[i]),       64'(e.err[i]));
                    end
                end
            end
            fin_d = bus.finish;
        end
    end

    initial begin
        int cyc;
        int fin_cnt;
        logic prev;

        bus.start = 1'b0;
        load_set(1'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy",    bus.busy, 0);
        check("reset_finish",  bus.finish, 0);
        check("reset_n_total", 64'(|bus.n_total), 0);
        check("reset_t0",      64'(|bus.t0), 0);
        check("reset_dir",     bus.dir, 0);
        check("reset_err",     bus.err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-pulse run of set A with latency bound.
        sb.push_back(build_exp(1'b0));
        bus.start = 1'b1;
        @(negedge clk);
        check("accept_busy",   bus.busy, 1);
        check("accept_finish", bus.finish, 0);
        bus.start = 1'b0;
        run_wait(cyc);
        check("latency_within_bound", 64'(cyc <= BOUND), 1);
        check("done_busy",   bus.busy, 0);
        check("done_finish", bus.finish, 1);

        // Second start while busy, with altered inputs, must be ignored.
        sb.push_back(build_exp(1'b0));
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (50) @(negedge clk);
        bus.num[0 +: W] = 7;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        run_wait(cyc);
        load_set(1'b0);
        repeat (5) @(negedge clk);
        check("ignored_start_busy", bus.busy, 0);

        // Level-held start: exactly one run per finish, stop after two.
        sb.push_back(build_exp(1'b0));
        sb.push_back(build_exp(1'b0));
        bus.start = 1'b1;
        fin_cnt = 0;
        prev = bus.finish;
        cyc = 0;
        while (fin_cnt < 2 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (bus.finish && !prev) fin_cnt++;
            prev = bus.finish;
        end
        bus.start = 1'b0;
        check("held_start_runs", fin_cnt, 2);
        repeat (10) @(negedge clk);
        check("held_idle_busy",   bus.busy, 0);
        check("held_finish_kept", bus.finish, 1);
        check("held_pending",     sb.size(), 0);

        // Abort in the middle of axis 2's nn division with set B.
        load_set(1'b1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (690) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy",    bus.busy, 0);
        check("abort_finish",  bus.finish, 0);
        check("abort_n_total", 64'(|bus.n_total), 0);
        check("abort_nn",      64'(|bus.nn), 0);
        check("abort_t0",      64'(|bus.t0), 0);
        check("abort_tna",     64'(|bus.tna), 0);
        check("abort_delta",   64'(|bus.delta), 0);
        check("abort_dir",     bus.dir, 0);
        check("abort_err",     bus.err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fresh run of set B after the abort.
        sb.push_back(build_exp(1'b1));
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        run_wait(cyc);
        check("setb_latency_within_bound", 64'(cyc <= BOUND), 1);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/speed_profile_planner.md
Name: speed_profile_planner

Overview:
- Multi-axis trapezoidal step-timing planner sitting between the G-code move decoder and the per-axis step generators.
- Converts each axis's signed step count, cruise speed, acceleration and start speed (jerk) into timing parameters in clock cycles:
  - total steps, acceleration step count, start period, cruise period, per-step period decrement, direction.
- Parametrised successor to the fixed 5-axis speeds_to_timings. Adds:
  - configurable axis count and width
  - one shared sequential divider
  - triangular-profile clamping for short moves
  - per-axis error flags and zero-step skipping

Parameters:
N_AXES, 5, number of axes (X, Y, Z, E0, E1 order for index 0..4).
WIDTH, 32, width of every input and output field.
CLK_HZ, 50_000_000, clock frequency; numerator for period divisions.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
start  in  1  request; sampled only in IDLE.
num  in  N_AXES*WIDTH  signed step counts, axis i at [i*WIDTH +: WIDTH].
speed  in  N_AXES*WIDTH  cruise speed, steps/s, unsigned.
acceleration  in  N_AXES*WIDTH  steps/s^2, unsigned.
jerk  in  N_AXES*WIDTH  start speed, steps/s, unsigned.
n_total  out  N_AXES*WIDTH  |num|.
nn  out  N_AXES*WIDTH  acceleration (= deceleration) step count.
t0  out  N_AXES*WIDTH  start period, clk cycles.
tna  out  N_AXES*WIDTH  cruise period, clk cycles.
delta  out  N_AXES*WIDTH  period decrement per accel step.
dir  out  N_AXES  1 = negative num.
err  out  N_AXES  axis had speed==0 or jerk==0 with num!=0.
busy  out  1  computation in progress.
finish  out  1  results valid.

Behaviour:
- Reset (reset==0, asynchronous): all outputs 0, FSM to IDLE, divider cleared.
  - Asserting reset mid-computation aborts it; no partial results are retained.
- Handshake:
  - In IDLE, start==1 latches all inputs, sets busy=1 and clears finish the next cycle.
  - start is ignored while busy.
  - finish rises with busy falling; it is held until the next accepted start or reset.
  - A level-held start re-triggers only after finish is set and start is sampled again in IDLE. Each accepted start restarts from the freshly latched inputs.
- FSM states: IDLE -> LATCH -> AXIS_SETUP -> DIV_TNA -> DIV_T0 -> MUL -> DIV_NN -> CLAMP -> DIV_DELTA -> STORE.
  - STORE goes to AXIS_SETUP for axis+1, or to DONE after axis N_AXES-1.
  - DONE -> IDLE.
- Arithmetic per axis, all unsigned and truncating:
  - N = |num|; dir = num[WIDTH-1].
  - tna = CLK_HZ / speed.
  - t0 = CLK_HZ / jerk.
  - If speed > jerk: nn = (speed^2 - jerk^2) / (2*acceleration). Products use 2*WIDTH bits.
  - If speed <= jerk: nn = 0, t0 = tna.
  - Acceleration == 0 with speed > jerk: nn = 0, t0 = tna.
  - CLAMP: if 2*nn > N then nn = N/2 (triangular profile).
  - delta = (t0 - tna) / nn when nn != 0, else 0.
  - Results wider than WIDTH saturate to all-ones.
- Skip and error rules:
  - N == 0: all fields 0, err 0, dir 0. All divisions are skipped (AXIS_SETUP -> STORE).
  - speed == 0 or jerk == 0 with N != 0: err=1, n_total=N, dir valid, other fields 0, divisions skipped.
- Divider: single restoring divider with 2*WIDTH-bit dividend and WIDTH-bit divisor. Each division takes exactly 2*WIDTH+1 cycles.
- Latency:
  - Per non-skipped axis: at most 4*(2*WIDTH+1)+6 cycles.
  - Skipped axis: 2 cycles.
  - Total bounded by N_AXES*(8*WIDTH+10)+3.
- Output update: outputs for axis i update in its STORE cycle; only finish qualifies them.

Test Plan:
- Axis 0: num=2200, speed=100, acceleration=100, jerk=10 -> n_total=2200, nn=49, t0=5000000, tna=500000, delta=91836, dir=0, err=0.
- Axis 1: num=-60, same speed/acceleration/jerk -> triangular: n_total=60, nn=30, delta=150000, dir=1.
- Axis 2: num=0 -> all fields 0; axis completes in 2 cycles. Axis 3: jerk=0, num=500 -> err[3]=1, n_total=500, other fields 0.
- Axis 4: num=300, speed=5, jerk=10 -> nn=0, t0=tna=10000000, delta=0.
- Hold start high through the run -> exactly one computation per finish. A second start pulse while busy is ignored. Check total cycles are within the latency bound.
- Deassert reset mid-DIV_NN of axis 2 -> all outputs 0 immediately. A new start then produces results identical to a clean run.
